// File: rtl/ofdm_tx_pkg.sv
// Shared constants and types for the 802.22 OFDM TX chain.
// CP_SEL encoding and read FSM states used by ofdm_cp_insert.
package ofdm_tx_pkg;

  localparam int NFFT_DEF = 256;
  localparam int SAMPLE_W = 32;

  localparam logic [1:0] CP_SEL_D4  = 2'd0;
  localparam logic [1:0] CP_SEL_D8  = 2'd1;
  localparam logic [1:0] CP_SEL_D16 = 2'd2;
  localparam logic [1:0] CP_SEL_D32 = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_t;

  function automatic int unsigned cp_len(
    input logic [1:0]  sel,
    input int unsigned nfft
  );
    int unsigned len;
    case (sel)
      CP_SEL_D8:  len = nfft / 8;
      CP_SEL_D16: len = nfft / 16;
      CP_SEL_D32: len = nfft / 32;
      default:    len = nfft / 4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ofdm_cp_dpram.sv
// Ping-pong sample store: one write port, one synchronous read port.
// Address is {bank, idx}; the array itself carries no reset.
module ofdm_cp_dpram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix insertion: buffers NFFT samples, emits last ncp then all NFFT.
// Define CP_SEL_EN to add the CP_SEL port (runtime CP length select).
module ofdm_cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int NFFT = NFFT_DEF,
  parameter int NCP  = 32,
  parameter int DW   = SAMPLE_W
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          WE_I,
  input  logic          STB_I,
  input  logic          CYC_I,
  output logic          ACK_O,
`ifdef CP_SEL_EN
  input  logic [1:0]    CP_SEL,
`endif
  output logic [DW-1:0] DAT_O,
  output logic          WE_O,
  output logic          STB_O,
  output logic          CYC_O,
  input  logic          ACK_I
);

  localparam int AW = $clog2(NFFT);

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic [1:0]    full_q, full_d;
  rd_state_t     st_q, st_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          stb_q, stb_d;
  logic          cyc_q, cyc_d;
  logic          last_q, last_d;
  logic          obank_q, obank_d;

  logic          ack;
  logic          out_xfer;
  logic          load;
  logic          idx_end;
  logic [AW-1:0] ncp_sel;
  logic [AW-1:0] cp_start;
  logic [DW-1:0] rdata;

`ifdef CP_SEL_EN
  assign ncp_sel = AW'(cp_len(CP_SEL, NFFT));
`else
  assign ncp_sel = AW'(NCP);
`endif
  // NFFT is a power of two, so NFFT-ncp wraps to the two's complement.
  assign cp_start = ~ncp_sel + AW'(1);

  assign ack      = ~RST_I & STB_I & CYC_I & WE_I & ~full_q[wr_bank_q];
  assign out_xfer = stb_q & cyc_q & ACK_I;
  assign load     = (st_q != RD_IDLE) & (~stb_q | ACK_I);
  assign idx_end  = (idx_q == AW'(NFFT - 1));

  ofdm_cp_dpram #(
    .AW (AW + 1),
    .DW (DW)
  ) u_ram (
    .clk   (CLK_I),
    .we    (ack),
    .waddr ({wr_bank_q, wr_cnt_q}),
    .wdata (DAT_I),
    .raddr ({rd_bank_d, idx_d}),
    .rdata (rdata)
  );

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    if (!CYC_I) begin
      wr_cnt_d = '0;
    end else if (ack) begin
      if (wr_cnt_q == AW'(NFFT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
    if (out_xfer && last_q) full_d[obank_q] = 1'b0;
  end

  // Read pointer runs one sample ahead of DAT_O; RAM always reads the next one.
  always_comb begin
    st_d      = st_q;
    idx_d     = idx_q;
    rd_bank_d = rd_bank_q;
    dat_d     = dat_q;
    stb_d     = stb_q & ~ACK_I;
    last_d    = last_q;
    obank_d   = obank_q;
    if (load) begin
      dat_d   = rdata;
      stb_d   = 1'b1;
      obank_d = rd_bank_q;
      last_d  = (st_q == RD_BODY) && idx_end;
    end
    unique case (st_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          st_d  = RD_CP;
          idx_d = cp_start;
        end
      end
      RD_CP: begin
        if (load) begin
          if (idx_end) begin
            st_d  = RD_BODY;
            idx_d = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      RD_BODY: begin
        if (load) begin
          if (idx_end) begin
            rd_bank_d = ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              st_d  = RD_CP;
              idx_d = cp_start;
            end else begin
              st_d = RD_IDLE;
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: st_d = RD_IDLE;
    endcase
  end

  always_comb begin
    cyc_d = cyc_q;
    if (stb_d) cyc_d = 1'b1;
    else if (st_d == RD_IDLE && full_d == 2'b00 && !CYC_I) cyc_d = 1'b0;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      st_q      <= RD_IDLE;
      idx_q     <= '0;
      rd_bank_q <= 1'b0;
      dat_q     <= '0;
      stb_q     <= 1'b0;
      cyc_q     <= 1'b0;
      last_q    <= 1'b0;
      obank_q   <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      st_q      <= st_d;
      idx_q     <= idx_d;
      rd_bank_q <= rd_bank_d;
      dat_q     <= dat_d;
      stb_q     <= stb_d;
      cyc_q     <= cyc_d;
      last_q    <= last_d;
      obank_q   <= obank_d;
    end
  end

  assign ACK_O = ack;
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;
  assign CYC_O = cyc_q;

endmodule
